// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter
// ----------------------------------------------------------------------------
// Shares one single-ported memory between the instruction fetch stage and the
// data (MEM) stage of a pipelined core. At most one memory transaction is
// outstanding. Ties are broken round-robin, and data wins the first tie after
// reset.
//
// Ports
//   clk_i, rst_i      clock (rising edge) / asynchronous active-low reset
//   if_req_i/addr_i   instruction fetch request and address
//   dm_read_i/write_i data load / store request from the MEM stage
//   dm_addr_i/wdata_i data address and store data
//   mem_ack_i/rdata_i memory completion strobe and read data
//   mem_req_o/we_o    registered request and write enable to memory
//   mem_addr_o/wdata_o registered address / write data, held while requesting
//   if_rdata_o/valid_o fetched instruction with a one-cycle valid pulse
//   dm_rdata_o        load data (updated on load completion only)
//   memStall_o        freeze EX/MEM and earlier while a data access is pending
//   ifStall_o         freeze PC and IF/ID while any access is pending
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              dm_read_i,
    input  logic              dm_write_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [ADDR_W-1:0] dm_wdata_i,
    input  logic              mem_ack_i,
    input  logic [ADDR_W-1:0] mem_rdata_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [ADDR_W-1:0] mem_wdata_o,
    output logic [ADDR_W-1:0] if_rdata_o,
    output logic              if_valid_o,
    output logic [ADDR_W-1:0] dm_rdata_o,
    output logic              memStall_o,
    output logic              ifStall_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_INST = 2'd2
    } state_t;

    localparam logic GRANT_DATA = 1'b0;
    localparam logic GRANT_INST = 1'b1;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              dm_done_q, dm_done_d;
    logic              if_done_q, if_done_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [ADDR_W-1:0] if_rdata_q, if_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic [ADDR_W-1:0] dm_rdata_q, dm_rdata_d;

    logic              dm_pend;
    logic              if_pend;
    logic              grant_data;
    logic              grant_inst;

    // A request whose completion is being reported this cycle is not pending,
    // which keeps it from being granted a second time.
    assign dm_pend = (dm_read_i | dm_write_i) & ~dm_done_q;
    assign if_pend = if_req_i & ~if_done_q;

    // Arbitration decision, only meaningful while idle.
    always_comb begin
        grant_data = 1'b0;
        grant_inst = 1'b0;
        if (state_q == ST_IDLE) begin
            grant_data = dm_pend & (~if_pend | (last_grant_q == GRANT_INST));
            grant_inst = if_pend & ~grant_data;
        end else begin
            grant_data = 1'b0;
            grant_inst = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; acks are only honoured in DATA/INST.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_data) begin
                    state_d = ST_DATA;
                end else if (grant_inst) begin
                    state_d = ST_INST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA, ST_INST: begin
                if (mem_ack_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output logic: latch request fields on grant, capture read data on ack.
    always_comb begin
        last_grant_d = last_grant_q;
        dm_done_d    = 1'b0;
        if_done_d    = 1'b0;
        if_valid_d   = 1'b0;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_data) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_write_i;
                    mem_addr_d  = dm_addr_i;
                    mem_wdata_d = dm_wdata_i;
                end else if (grant_inst) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr_i;
                    mem_wdata_d = {ADDR_W{1'b0}};
                end else begin
                    mem_req_d = 1'b0;
                end
            end
            ST_DATA: begin
                if (mem_ack_i) begin
                    mem_req_d    = 1'b0;
                    last_grant_d = GRANT_DATA;
                    dm_done_d    = 1'b1;
                    // Stores complete without touching the load data register.
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata_i;
                    end else begin
                        dm_rdata_d = dm_rdata_q;
                    end
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            ST_INST: begin
                if (mem_ack_i) begin
                    mem_req_d    = 1'b0;
                    last_grant_d = GRANT_INST;
                    if_done_d    = 1'b1;
                    if_valid_d   = 1'b1;
                    if_rdata_d   = mem_rdata_i;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            default: begin
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Datapath and bookkeeping registers; reset abandons any transaction.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_grant_q <= GRANT_INST;
            dm_done_q    <= 1'b0;
            if_done_q    <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_wdata_q  <= {ADDR_W{1'b0}};
            if_rdata_q   <= {ADDR_W{1'b0}};
            if_valid_q   <= 1'b0;
            dm_rdata_q   <= {ADDR_W{1'b0}};
        end else begin
            last_grant_q <= last_grant_d;
            dm_done_q    <= dm_done_d;
            if_done_q    <= if_done_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            if_valid_q   <= if_valid_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_rdata_o  = if_rdata_q;
    assign if_valid_o  = if_valid_q;
    assign dm_rdata_o  = dm_rdata_q;

    // Stalls must react in the same cycle the pipeline raises a request.
    assign memStall_o  = dm_pend;
    assign ifStall_o   = if_pend | dm_pend;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: expected memory transactions are
// queued when a request is driven and compared when the arbiter grants and
// completes them.
module tb_mem_port_arbiter;

    typedef struct {
        logic        inst;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        dm_read_i;
    logic        dm_write_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] if_rdata_o;
    logic        if_valid_o;
    logic [31:0] dm_rdata_o;
    logic        memStall_o;
    logic        ifStall_o;

    txn_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_dm_rdata;
    logic [31:0] exp_if_rdata;

    mem_port_arbiter #(.ADDR_W(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .dm_read_i   (dm_read_i),
        .dm_write_i  (dm_write_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .if_rdata_o  (if_rdata_o),
        .if_valid_o  (if_valid_o),
        .dm_rdata_o  (dm_rdata_o),
        .memStall_o  (memStall_o),
        .ifStall_o   (ifStall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic txn_t mk(input logic inst, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata);
        txn_t t;
        t.inst  = inst;
        t.we    = we;
        t.addr  = addr;
        t.wdata = wdata;
        t.rdata = rdata;
        return t;
    endfunction

    // Memory responder: acks each granted request on its ack_n-th request
    // cycle and checks grants and completions against the expected queue.
    // Entered mid-cycle right after the caller drove the request; returns
    // mid-cycle in the completion cycle of the n-th transaction.
    task automatic serve(input int n, input int ack_n, output int st, output int ist,
                         output int bursts);
        int          got      = 0;
        int          req_cnt  = 0;
        int          cyc      = 0;
        logic        prev_req = 1'b0;
        logic        done_cyc = 1'b0;
        logic [31:0] saved_addr = 32'h0;
        txn_t        cur = mk(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        st = 0;
        ist = 0;
        bursts = 0;
        while (got < n && cyc < 200) begin
            #1;
            cyc++;
            if (memStall_o) st++;
            if (ifStall_o) ist++;
            if (memStall_o && !ifStall_o) check_eq("ifstall_covers_memstall", 32'(ifStall_o), 32'd1);
            check_eq("if_valid", 32'(if_valid_o), 32'(done_cyc && cur.inst));
            mem_ack_i = 1'b0;
            if (done_cyc) begin
                if (cur.inst) begin
                    check_eq("if_rdata", if_rdata_o, cur.rdata);
                    exp_if_rdata = cur.rdata;
                end else begin
                    if (!cur.we) exp_dm_rdata = cur.rdata;
                    check_eq("dm_rdata", dm_rdata_o, exp_dm_rdata);
                end
                check_eq("req_low_after_ack", 32'(mem_req_o), 32'd0);
                got++;
                done_cyc = 1'b0;
            end else if (mem_req_o) begin
                if (!prev_req) begin
                    bursts++;
                    req_cnt = 0;
                    saved_addr = dm_addr_i;
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_grant", 32'd1, 32'd0);
                    end else begin
                        cur = exp_q.pop_front();
                    end
                end
                req_cnt++;
                check_eq("mem_addr", mem_addr_o, cur.addr);
                check_eq("mem_we", 32'(mem_we_o), 32'(cur.we));
                check_eq("mem_wdata", mem_wdata_o, cur.wdata);
                if (req_cnt >= ack_n) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = cur.rdata;
                    done_cyc    = 1'b1;
                    if (!cur.inst) dm_addr_i = saved_addr;
                end else begin
                    mem_rdata_i = $urandom;
                    // The latched address must not follow the live input.
                    if (!cur.inst) dm_addr_i = saved_addr ^ 32'hFFFF_0000 ^ 32'(req_cnt);
                end
            end
            prev_req = mem_req_o;
            if (got < n) @(negedge clk_i);
        end
        if (got < n) check_eq("serve_timeout", 32'(got), 32'(n));
    endtask

    task automatic idle_inputs();
        if_req_i    = 1'b0;
        if_addr_i   = 32'h0;
        dm_read_i   = 1'b0;
        dm_write_i  = 1'b0;
        dm_addr_i   = 32'h0;
        dm_wdata_i  = 32'h0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
    endtask

    initial begin : main
        int st;
        int ist;
        int bursts;
        int waited;
        idle_inputs();
        rst_i = 1'b0;
        exp_dm_rdata = 32'h0;
        exp_if_rdata = 32'h0;
        repeat (3) @(negedge clk_i);
        #1;
        check_eq("rst_mem_req", 32'(mem_req_o), 32'd0);
        check_eq("rst_mem_we", 32'(mem_we_o), 32'd0);
        check_eq("rst_mem_addr", mem_addr_o, 32'h0);
        check_eq("rst_mem_wdata", mem_wdata_o, 32'h0);
        check_eq("rst_if_rdata", if_rdata_o, 32'h0);
        check_eq("rst_if_valid", 32'(if_valid_o), 32'd0);
        check_eq("rst_dm_rdata", dm_rdata_o, 32'h0);
        check_eq("rst_memstall", 32'(memStall_o), 32'd0);
        check_eq("rst_ifstall", 32'(ifStall_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Load, ack on the third request cycle.
        @(negedge clk_i);
        dm_read_i = 1'b1;
        dm_addr_i = 32'h40;
        exp_q.push_back(mk(1'b0, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF));
        serve(1, 3, st, ist, bursts);
        dm_read_i = 1'b0;
        check_eq("load_stall_cycles", 32'(st), 32'd4);
        check_eq("load_bursts", 32'(bursts), 32'd1);

        // Stray ack in idle.
        @(negedge clk_i);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hCAFEF00D;
        repeat (2) @(negedge clk_i);
        mem_ack_i = 1'b0;
        #1;
        check_eq("stray_mem_req", 32'(mem_req_o), 32'd0);
        check_eq("stray_dm_rdata", dm_rdata_o, exp_dm_rdata);
        check_eq("stray_if_rdata", if_rdata_o, exp_if_rdata);
        check_eq("stray_if_valid", 32'(if_valid_o), 32'd0);

        // Store, immediate ack; dm_rdata_o must keep the load value.
        @(negedge clk_i);
        dm_write_i = 1'b1;
        dm_addr_i  = 32'h80;
        dm_wdata_i = 32'h12345678;
        exp_q.push_back(mk(1'b0, 1'b1, 32'h80, 32'h12345678, 32'h55AA55AA));
        serve(1, 1, st, ist, bursts);
        dm_write_i = 1'b0;
        dm_wdata_i = 32'h0;
        check_eq("store_stall_cycles", 32'(st), 32'd2);
        check_eq("store_bursts", 32'(bursts), 32'd1);

        // Fetch only, ack on second request cycle.
        @(negedge clk_i);
        if_req_i  = 1'b1;
        if_addr_i = 32'h1000;
        exp_q.push_back(mk(1'b1, 1'b0, 32'h1000, 32'h0, 32'h00000013));
        serve(1, 2, st, ist, bursts);
        if_req_i = 1'b0;
        check_eq("fetch_memstall_cycles", 32'(st), 32'd0);
        check_eq("fetch_ifstall_cycles", 32'(ist), 32'd3);
        @(negedge clk_i);
        #1;
        check_eq("if_valid_one_cycle", 32'(if_valid_o), 32'd0);

        // Contention from reset release: DATA, INST, DATA, INST.
        @(negedge clk_i);
        rst_i     = 1'b0;
        if_req_i  = 1'b1;
        if_addr_i = 32'h200;
        dm_read_i = 1'b1;
        dm_addr_i = 32'h100;
        exp_dm_rdata = 32'h0;
        exp_if_rdata = 32'h0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b0, 32'h100, 32'h0, 32'hD0000001));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h200, 32'h0, 32'h10000001));
        exp_q.push_back(mk(1'b0, 1'b0, 32'h100, 32'h0, 32'hD0000002));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h200, 32'h0, 32'h10000002));
        serve(4, 1, st, ist, bursts);
        if_req_i  = 1'b0;
        dm_read_i = 1'b0;
        check_eq("contention_bursts", 32'(bursts), 32'd4);
        check_eq("contention_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a data access.
        @(negedge clk_i);
        dm_read_i = 1'b1;
        dm_addr_i = 32'h300;
        waited = 0;
        #1;
        while (!mem_req_o && waited < 10) begin
            @(negedge clk_i);
            #1;
            waited++;
        end
        check_eq("midop_req_seen", 32'(mem_req_o), 32'd1);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check_eq("midop_mem_req", 32'(mem_req_o), 32'd0);
        check_eq("midop_mem_addr", mem_addr_o, 32'h0);
        check_eq("midop_dm_rdata", dm_rdata_o, 32'h0);
        check_eq("midop_if_rdata", if_rdata_o, 32'h0);
        dm_read_i = 1'b0;
        @(negedge clk_i);
        rst_i       = 1'b1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hBADBAD00;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        #1;
        check_eq("late_ack_dm_rdata", dm_rdata_o, 32'h0);
        check_eq("late_ack_mem_req", 32'(mem_req_o), 32'd0);
        check_eq("late_ack_if_valid", 32'(if_valid_o), 32'd0);
        check_eq("late_ack_memstall", 32'(memStall_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
